fetch_stage: RTL and testbench

Instruction-fetch stage that feeds the byte-addressed instruction ROM and consumes its 32-bit word. Holds the program counter (reset vector 0xBFC00000), drives the ROM address, and captures the returned word with its PC into an IF/ID register. Supports pipeline stall, redirect/flush from execute, and a sticky fault state for misaligned or out-of-range fetch addresses. Sits between the branch/jump resolution logic and the instruction memory/decode stage.

---
 rtl/fetch_stage_if.sv | 57 +++++
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage control, instruction-memory and IF/ID signals.
// Latency: n/a (wiring only); imem_addr_o -> imem_data_i path is combinational.
// Backpressure: stall_i from the downstream pipeline is the only hold mechanism.
interface fetch_stage_if #(
  parameter int A_WIDTH = 32
);

  // Pipeline control from execute / hazard logic
  logic               stall_i;
  logic               flush_i;
  logic [A_WIDTH-1:0] redirect_pc_i;

  // Instruction memory port (byte address out, word back same cycle)
  logic [A_WIDTH-1:0] imem_addr_o;
  logic [31:0]        imem_data_i;

  // IF/ID pipeline register contents
  logic               if_id_valid_o;
  logic [31:0]        if_id_instr_o;
  logic [A_WIDTH-1:0] if_id_pc_o;
  logic [A_WIDTH-1:0] if_id_pc_plus4_o;

  // Sticky fetch fault report
  logic               fault_o;
  logic [A_WIDTH-1:0] fault_pc_o;

  // Fetch stage side
  modport slave (
    input  stall_i,
    input  flush_i,
    input  redirect_pc_i,
    input  imem_data_i,
    output imem_addr_o,
    output if_id_valid_o,
    output if_id_instr_o,
    output if_id_pc_o,
    output if_id_pc_plus4_o,
    output fault_o,
    output fault_pc_o
  );

  // Surrounding pipeline / memory side
  modport master (
    output stall_i,
    output flush_i,
    output redirect_pc_i,
    output imem_data_i,
    input  imem_addr_o,
    input  if_id_valid_o,
    input  if_id_instr_o,
    input  if_id_pc_o,
    input  if_id_pc_plus4_o,
    input  fault_o,
    input  fault_pc_o
  );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, ROM address drive, IF/ID capture, sticky fetch fault.
// Latency: word at pc lands in IF/ID on the next rising edge; redirect costs one bubble.
// Backpressure: stall_i freezes pc and IF/ID; flush_i overrides stall; FAULT ignores both.
module fetch_stage #(
  parameter int                 A_WIDTH      = 32,
  parameter logic [A_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter int                 ROM_BYTES    = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.slave  bus
);

  // Highest word-aligned PC that still lies inside the ROM window
  localparam logic [A_WIDTH-1:0] LAST_PC = RESET_VECTOR + A_WIDTH'(ROM_BYTES - 4);
  localparam logic [A_WIDTH-1:0] PC_STEP = A_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [A_WIDTH-1:0] pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [31:0]        instr_q, instr_d;
  logic [A_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [A_WIDTH-1:0] id_pc4_q, id_pc4_d;
  logic               fault_q, fault_d;
  logic [A_WIDTH-1:0] fault_pc_q, fault_pc_d;

  logic [A_WIDTH-1:0] pc_plus4;
  logic               pc_misaligned;
  logic               pc_below;
  logic               pc_above;
  logic               pc_illegal;

  // Per-edge actions decoded from state and inputs (mutually exclusive)
  logic do_redirect;
  logic do_fault;
  logic do_capture;

  // Modulo-2^A_WIDTH increment; a wrap lands below the ROM base and faults
  assign pc_plus4      = pc_q + PC_STEP;
  assign pc_misaligned = |pc_q[1:0];
  assign pc_below      = (pc_q < RESET_VECTOR);
  assign pc_above      = (pc_q > LAST_PC);
  assign pc_illegal    = pc_misaligned | pc_below | pc_above;

  // State register: async reset returns to BOOT immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: one BOOT settle cycle, RUN until an illegal fetch, FAULT is terminal
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (do_fault) state_d = ST_FAULT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase
  end

  // Output decode: in RUN, flush beats the legality check, which beats stall
  always_comb begin
    do_redirect = 1'b0;
    do_fault    = 1'b0;
    do_capture  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.flush_i) begin
          do_redirect = 1'b1;
        end else if (pc_illegal) begin
          do_fault = 1'b1;
        end else if (!bus.stall_i) begin
          do_capture = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath next values; everything holds unless one action fires
  always_comb begin
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;

    if (do_redirect) begin
      // Squash only the valid bit; the stale payload is harmless once invalid
      valid_d = 1'b0;
      pc_d    = bus.redirect_pc_i;
    end

    if (do_fault) begin
      valid_d    = 1'b0;
      fault_d    = 1'b1;
      fault_pc_d = pc_q;
    end

    if (do_capture) begin
      valid_d  = 1'b1;
      instr_d  = bus.imem_data_i;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
      pc_d     = pc_plus4;
    end
  end

  // PC, IF/ID and fault registers with async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // ROM address follows pc in every state, including FAULT
  assign bus.imem_addr_o      = pc_q;
  assign bus.if_id_valid_o    = valid_q;
  assign bus.if_id_instr_o    = instr_q;
  assign bus.if_id_pc_o       = id_pc_q;
  assign bus.if_id_pc_plus4_o = id_pc4_q;
  assign bus.fault_o          = fault_q;
  assign bus.fault_pc_o       = fault_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, redirect, fault and async reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall_i/flush_i driven directly from scenario tasks.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fetch_stage_if #(.A_WIDTH(32)) bus ();

  fetch_stage #(
    .A_WIDTH      (32),
    .RESET_VECTOR (32'hBFC00000),
    .ROM_BYTES    (4096)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: two fixed program words, address-derived filler elsewhere
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'hBFC00000: rom_word = 32'h00500093;
      32'hBFC00004: rom_word = 32'h00100113;
      default:      rom_word = {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  assign bus.imem_data_i = rom_word(bus.imem_addr_o);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset and run through BOOT with no checks, leaving pc=0xBFC00000 in RUN
  task automatic reset_and_boot();
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    #12;
    n_checks++; if (bus.if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0h exp=0", bus.if_id_valid_o); end
    n_checks++; if (bus.if_id_instr_o !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h exp=0", bus.if_id_instr_o); end
    n_checks++; if (bus.if_id_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=0", bus.if_id_pc_o); end
    n_checks++; if (bus.if_id_pc_plus4_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc4 got=%h exp=0", bus.if_id_pc_plus4_o); end
    n_checks++; if (bus.fault_o !== 1'b0 || bus.fault_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_fault got=%0h/%h exp=0/0", bus.fault_o, bus.fault_pc_o); end
    n_checks++; if (bus.imem_addr_o !== 32'hBFC00000) begin n_fail++; $display("FAIL rst_addr got=%h exp=bfc00000", bus.imem_addr_o); end
    rst_n = 1'b1;
    // Edge 1: BOOT -> RUN, nothing captured, pc unchanged
    step();
    n_checks++; if (bus.if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL boot_valid got=%0h exp=0", bus.if_id_valid_o); end
    n_checks++; if (bus.imem_addr_o !== 32'hBFC00000) begin n_fail++; $display("FAIL boot_addr got=%h exp=bfc00000", bus.imem_addr_o); end
    // Edge 2: first capture
    step();
    n_checks++; if (bus.if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL cap0_valid got=%0h exp=1", bus.if_id_valid_o); end
    n_checks++; if (bus.if_id_instr_o !== 32'h00500093) begin n_fail++; $display("FAIL cap0_instr got=%h exp=00500093", bus.if_id_instr_o); end
    n_checks++; if (bus.if_id_pc_o !== 32'hBFC00000) begin n_fail++; $display("FAIL cap0_pc got=%h exp=bfc00000", bus.if_id_pc_o); end
    n_checks++; if (bus.if_id_pc_plus4_o !== 32'hBFC00004) begin n_fail++; $display("FAIL cap0_pc4 got=%h exp=bfc00004", bus.if_id_pc_plus4_o); end
    n_checks++; if (bus.imem_addr_o !== 32'hBFC00004) begin n_fail++; $display("FAIL cap0_addr got=%h exp=bfc00004", bus.imem_addr_o); end
    step();
    n_checks++; if (bus.if_id_instr_o !== 32'h00100113) begin n_fail++; $display("FAIL cap1_instr got=%h exp=00100113", bus.if_id_instr_o); end
    n_checks++; if (bus.if_id_pc_o !== 32'hBFC00004) begin n_fail++; $display("FAIL cap1_pc got=%h exp=bfc00004", bus.if_id_pc_o); end
  endtask

  task automatic test_stall();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus.imem_addr_o !== 32'hBFC00008) begin n_fail++; $display("FAIL stall_addr[%0d] got=%h exp=bfc00008", i, bus.imem_addr_o); end
      n_checks++; if (bus.if_id_instr_o !== 32'h00100113 || bus.if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d] got=%h/%0h exp=00100113/1", i, bus.if_id_instr_o, bus.if_id_valid_o); end
    end
    bus.stall_i = 1'b0;
    step();
    n_checks++; if (bus.if_id_instr_o !== rom_word(32'hBFC00008)) begin n_fail++; $display("FAIL resume_instr got=%h exp=%h", bus.if_id_instr_o, rom_word(32'hBFC00008)); end
    n_checks++; if (bus.if_id_pc_o !== 32'hBFC00008) begin n_fail++; $display("FAIL resume_pc got=%h exp=bfc00008", bus.if_id_pc_o); end
  endtask

  task automatic test_flush_over_stall();
    bus.flush_i = 1'b1;
    bus.stall_i = 1'b1;
    bus.redirect_pc_i = 32'hBFC00100;
    step();
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    n_checks++; if (bus.if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%0h exp=0", bus.if_id_valid_o); end
    n_checks++; if (bus.imem_addr_o !== 32'hBFC00100) begin n_fail++; $display("FAIL flush_addr got=%h exp=bfc00100", bus.imem_addr_o); end
    n_checks++; if (bus.if_id_pc_o !== 32'hBFC00008) begin n_fail++; $display("FAIL flush_pc_hold got=%h exp=bfc00008", bus.if_id_pc_o); end
    step();
    n_checks++; if (bus.if_id_valid_o !== 1'b1 || bus.if_id_pc_o !== 32'hBFC00100) begin n_fail++; $display("FAIL target_cap got=%0h/%h exp=1/bfc00100", bus.if_id_valid_o, bus.if_id_pc_o); end
    n_checks++; if (bus.if_id_instr_o !== rom_word(32'hBFC00100)) begin n_fail++; $display("FAIL target_instr got=%h exp=%h", bus.if_id_instr_o, rom_word(32'hBFC00100)); end
  endtask

  task automatic test_reset_mid_run();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.if_id_valid_o !== 1'b0 || bus.if_id_instr_o !== 32'h0) begin n_fail++; $display("FAIL async_valid_instr got=%0h/%h exp=0/0", bus.if_id_valid_o, bus.if_id_instr_o); end
    n_checks++; if (bus.if_id_pc_o !== 32'h0 || bus.if_id_pc_plus4_o !== 32'h0) begin n_fail++; $display("FAIL async_pcs got=%h/%h exp=0/0", bus.if_id_pc_o, bus.if_id_pc_plus4_o); end
    n_checks++; if (bus.imem_addr_o !== 32'hBFC00000) begin n_fail++; $display("FAIL async_addr got=%h exp=bfc00000", bus.imem_addr_o); end
    #2 rst_n = 1'b1;
    step();
    n_checks++; if (bus.if_id_valid_o !== 1'b0 || bus.imem_addr_o !== 32'hBFC00000) begin n_fail++; $display("FAIL reboot got=%0h/%h exp=0/bfc00000", bus.if_id_valid_o, bus.imem_addr_o); end
    step();
    n_checks++; if (bus.if_id_instr_o !== 32'h00500093 || bus.if_id_pc_o !== 32'hBFC00000) begin n_fail++; $display("FAIL reboot_cap got=%h/%h exp=00500093/bfc00000", bus.if_id_instr_o, bus.if_id_pc_o); end
  endtask

  task automatic test_top_boundary();
    bus.flush_i = 1'b1;
    bus.redirect_pc_i = 32'hBFC00FFC;
    step();
    bus.flush_i = 1'b0;
    step();
    n_checks++; if (bus.if_id_valid_o !== 1'b1 || bus.if_id_pc_o !== 32'hBFC00FFC) begin n_fail++; $display("FAIL last_cap got=%0h/%h exp=1/bfc00ffc", bus.if_id_valid_o, bus.if_id_pc_o); end
    n_checks++; if (bus.if_id_pc_plus4_o !== 32'hBFC01000 || bus.fault_o !== 1'b0) begin n_fail++; $display("FAIL last_pc4 got=%h/%0h exp=bfc01000/0", bus.if_id_pc_plus4_o, bus.fault_o); end
    step();
    n_checks++; if (bus.fault_o !== 1'b1 || bus.fault_pc_o !== 32'hBFC01000) begin n_fail++; $display("FAIL top_fault got=%0h/%h exp=1/bfc01000", bus.fault_o, bus.fault_pc_o); end
    n_checks++; if (bus.if_id_valid_o !== 1'b0 || bus.if_id_pc_o !== 32'hBFC00FFC) begin n_fail++; $display("FAIL top_ifid got=%0h/%h exp=0/bfc00ffc", bus.if_id_valid_o, bus.if_id_pc_o); end
  endtask

  task automatic test_misaligned_redirect();
    reset_and_boot();
    bus.flush_i = 1'b1;
    bus.redirect_pc_i = 32'hBFC00102;
    step();
    bus.flush_i = 1'b0;
    n_checks++; if (bus.fault_o !== 1'b0 || bus.if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL mis_flush_edge got=%0h/%0h exp=0/0", bus.fault_o, bus.if_id_valid_o); end
    n_checks++; if (bus.imem_addr_o !== 32'hBFC00102) begin n_fail++; $display("FAIL mis_addr got=%h exp=bfc00102", bus.imem_addr_o); end
    step();
    n_checks++; if (bus.fault_o !== 1'b1 || bus.fault_pc_o !== 32'hBFC00102) begin n_fail++; $display("FAIL mis_fault got=%0h/%h exp=1/bfc00102", bus.fault_o, bus.fault_pc_o); end
    // FAULT must ignore flush and stall
    bus.flush_i = 1'b1;
    bus.stall_i = 1'b1;
    bus.redirect_pc_i = 32'hBFC00000;
    step();
    step();
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    step();
    n_checks++; if (bus.imem_addr_o !== 32'hBFC00102 || bus.if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL fault_sticky got=%h/%0h exp=bfc00102/0", bus.imem_addr_o, bus.if_id_valid_o); end
    n_checks++; if (bus.fault_o !== 1'b1 || bus.fault_pc_o !== 32'hBFC00102) begin n_fail++; $display("FAIL fault_hold got=%0h/%h exp=1/bfc00102", bus.fault_o, bus.fault_pc_o); end
  endtask

  task automatic test_below_range();
    reset_and_boot();
    bus.flush_i = 1'b1;
    bus.redirect_pc_i = 32'hBFBFFFFC;
    step();
    bus.flush_i = 1'b0;
    n_checks++; if (bus.fault_o !== 1'b0) begin n_fail++; $display("FAIL below_flush_edge got=%0h exp=0", bus.fault_o); end
    step();
    n_checks++; if (bus.fault_o !== 1'b1 || bus.fault_pc_o !== 32'hBFBFFFFC) begin n_fail++; $display("FAIL below_fault got=%0h/%h exp=1/bfbffffc", bus.fault_o, bus.fault_pc_o); end
    // Reset clears the sticky fault
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.fault_o !== 1'b0 || bus.fault_pc_o !== 32'h0) begin n_fail++; $display("FAIL fault_clear got=%0h/%h exp=0/0", bus.fault_o, bus.fault_pc_o); end
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_stall();
    test_flush_over_stall();
    test_reset_mid_run();
    test_top_boundary();
    test_misaligned_redirect();
    test_below_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
